// File: rtl/seed_ctrl_pkg.sv
// seed_ctrl_pkg: state encoding, LFSR taps and default preset shared by seed_ctrl.
package seed_ctrl_pkg;
    typedef enum logic [2:0] {IDLE = 3'd0, RAND = 3'd1, READY = 3'd2, PLAY = 3'd3, PAUSE = 3'd4} state_t;
    localparam logic [63:0] DEFAULT_PRESET = 64'h0412_6424_0034_3CA8;
    function automatic logic [63:0] lfsr_taps(input int width);
        return width == 16 ? 64'hB400 : width == 32 ? 64'h8020_0003 : 64'hD800_0000_0000_0000;
    endfunction
endpackage

// File: rtl/seed_ctrl_if.sv
// seed_ctrl_if: control inputs and seed/status outputs of seed_ctrl.
interface seed_ctrl_if #(parameter int WIDTH = 64);
    logic start, randomize, pause, load_valid;
    logic [WIDTH-1:0] load_seed, seed_out;
    logic seed_valid, step;
    logic [2:0] state_o;
    logic [15:0] gen_count;
    modport master(output start, randomize, pause, load_valid, load_seed,
                   input seed_out, seed_valid, step, state_o, gen_count);
    modport slave(input start, randomize, pause, load_valid, load_seed,
                  output seed_out, seed_valid, step, state_o, gen_count);
endinterface

// File: rtl/seed_ctrl_galois_lfsr.sv
// galois_lfsr: Galois LFSR with priority load; a zero load falls back to PRESET to avoid lock-up.
module galois_lfsr #(
    parameter int WIDTH = 64,
    parameter logic [WIDTH-1:0] TAPS = '0,
    parameter logic [WIDTH-1:0] PRESET = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q <= PRESET;
        else if (load) q <= load_val == '0 ? PRESET : load_val;
        else if (en) q <= (q >> 1) ^ (q[0] ? TAPS : '0);
endmodule

// File: rtl/seed_ctrl.sv
// seed_ctrl: seed holder and IDLE/RAND/READY/PLAY/PAUSE sequencer with generation step strobe.
// External seed load is built only when SEED_CTRL_LOAD_EN is defined.
module seed_ctrl
    import seed_ctrl_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter logic [63:0] PRESET = DEFAULT_PRESET,
    parameter int STEP_DIV = 4
) (
    input logic clk,
    input logic reset,
    seed_ctrl_if.slave bus
);
    localparam int DW = $clog2(STEP_DIV);
    localparam logic [DW-1:0] LAST = DW'(STEP_DIV - 1);
    localparam logic [2:0] S_IDLE = IDLE, S_RAND = RAND, S_READY = READY, S_PLAY = PLAY, S_PAUSE = PAUSE;
    logic [2:0] state, nxt;
    logic [DW-1:0] div;
    logic [15:0] gen;
    logic [WIDTH-1:0] seed;
    logic valid, step, ld, adv, tick, clr;
`ifdef SEED_CTRL_LOAD_EN
    assign ld = bus.load_valid && (state == S_IDLE || state == S_READY || state == S_PAUSE);
`else
    assign ld = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = ld ? S_READY : (bus.randomize && bus.start) ? S_IDLE :
                           bus.randomize ? S_RAND : bus.start ? S_PLAY : S_IDLE;
            S_RAND:  nxt = bus.randomize ? S_RAND : S_READY;
            S_READY: nxt = ld ? S_READY : bus.randomize ? S_RAND : bus.start ? S_PLAY : S_READY;
            S_PLAY:  nxt = bus.randomize ? S_RAND : bus.pause ? S_PAUSE : S_PLAY;
            S_PAUSE: nxt = ld ? S_PAUSE : bus.randomize ? S_RAND : (bus.start && !bus.pause) ? S_PLAY : S_PAUSE;
            default: nxt = S_IDLE;
        endcase
    end
    // the divider advances on every edge that lands in PLAY, including the entry edge
    assign clr = ld || nxt == S_RAND;
    assign adv = nxt == S_PLAY;
    assign tick = adv && div == LAST;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= S_IDLE;
            valid <= 1'b1;
            step <= 1'b0;
            gen <= '0;
            div <= '0;
        end else begin
            state <= nxt;
            valid <= nxt != S_RAND;
            step <= tick;
            div <= (clr || tick || (state == S_IDLE && !adv)) ? '0 : div + DW'(adv);
            gen <= clr ? '0 : gen + 16'(tick);
        end
    galois_lfsr #(
        .WIDTH(WIDTH),
        .TAPS(WIDTH'(lfsr_taps(WIDTH))),
        .PRESET(PRESET[WIDTH-1:0])
    ) u_lfsr (
        .clk(clk),
        .reset(reset),
        .en(nxt == S_RAND),
        .load(ld),
        .load_val(bus.load_seed),
        .q(seed)
    );
    assign bus.seed_out = seed;
    assign bus.seed_valid = valid;
    assign bus.step = step;
    assign bus.state_o = state;
    assign bus.gen_count = gen;
endmodule

// File: tb/tb_seed_ctrl.sv
// tb_seed_ctrl: directed and randomized checks of seed_ctrl against a cycle-level behavioural model.
module tb_seed_ctrl;
    localparam int SD = 4;
    localparam logic [63:0] PRE = 64'h0412_6424_0034_3CA8;
    localparam logic [63:0] TAPS = 64'hD800_0000_0000_0000;
    localparam int S_IDLE = 0, S_RAND = 1, S_READY = 2, S_PLAY = 3, S_PAUSE = 4;
`ifdef SEED_CTRL_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0, fails = 0, nsteps;
    bit chk = 1'b0;
    int m_state, play_edges;
    logic [63:0] m_seed;
    bit m_step;

    seed_ctrl_if #(.WIDTH(64)) bus();
    seed_ctrl #(.WIDTH(64), .PRESET(PRE), .STEP_DIV(SD)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] galois(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 64'd0);
    endfunction

    task automatic m_reset;
        m_state = S_IDLE;
        m_seed = PRE;
        m_step = 1'b0;
        play_edges = 0;
    endtask

    // gen_count is derived as play_edges / SD: each SD-th edge spent in PLAY is a step
    task automatic m_edge;
        bit ld, rz, st, pz;
        int nx;
        rz = bus.randomize;
        st = bus.start;
        pz = bus.pause;
        ld = LOAD_EN && bus.load_valid && (m_state == S_IDLE || m_state == S_READY || m_state == S_PAUSE);
        nx = m_state;
        if (ld) nx = m_state == S_PAUSE ? S_PAUSE : S_READY;
        else case (m_state)
            S_IDLE:  nx = (rz && st) ? S_IDLE : rz ? S_RAND : st ? S_PLAY : S_IDLE;
            S_RAND:  nx = rz ? S_RAND : S_READY;
            S_READY: nx = rz ? S_RAND : st ? S_PLAY : S_READY;
            S_PLAY:  nx = rz ? S_RAND : pz ? S_PAUSE : S_PLAY;
            default: nx = rz ? S_RAND : (st && !pz) ? S_PLAY : S_PAUSE;
        endcase
        m_step = 1'b0;
        if (ld) begin
            m_seed = bus.load_seed == 64'd0 ? PRE : bus.load_seed;
            play_edges = 0;
        end else if (nx == S_RAND) begin
            m_seed = galois(m_seed);
            play_edges = 0;
        end else if (nx == S_PLAY) begin
            play_edges++;
            m_step = (play_edges % SD) == 0;
        end
        m_state = nx;
    endtask

    always @(negedge clk) if (chk) begin
        check("state", 64'(bus.state_o), 64'(m_state));
        check("seed", bus.seed_out, m_seed);
        check("seed_valid", 64'(bus.seed_valid), 64'(m_state != S_RAND));
        check("step", 64'(bus.step), 64'(m_step));
        check("gen_count", 64'(bus.gen_count), 64'((play_edges / SD) % 65536));
    end

    task automatic cycle(input bit st, input bit rz, input bit pz, input bit lv, input logic [63:0] ls);
        @(negedge clk);
        #1;
        bus.start = st;
        bus.randomize = rz;
        bus.pause = pz;
        bus.load_valid = lv;
        bus.load_seed = ls;
        @(posedge clk);
        if (!reset) m_edge();
        #1;
        if (bus.step) nsteps++;
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2;
        reset = 1'b1;
        bus.start = 0;
        bus.randomize = 0;
        bus.pause = 0;
        bus.load_valid = 0;
        m_reset();
        #1;
        check("async_reset_state", 64'(bus.state_o), 64'd0);
        check("async_reset_seed", bus.seed_out, PRE);
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        bus.start = 0;
        bus.randomize = 0;
        bus.pause = 0;
        bus.load_valid = 0;
        bus.load_seed = '0;
        m_reset();
        #12;
        check("reset_seed", bus.seed_out, 64'h0412_6424_0034_3CA8);
        check("reset_valid", 64'(bus.seed_valid), 64'd1);
        check("reset_step", 64'(bus.step), 64'd0);
        check("reset_gen", 64'(bus.gen_count), 64'd0);
        check("reset_state", 64'(bus.state_o), 64'd0);
        chk = 1'b1;
        reset = 1'b0;
        cycle(0, 1, 0, 0, 0);
        check("rand_state", 64'(bus.state_o), 64'd1);
        check("rand_valid", 64'(bus.seed_valid), 64'd0);
        cycle(0, 0, 0, 0, 0);
        check("ready_state", 64'(bus.state_o), 64'd2);
        check("ready_seed", bus.seed_out, 64'h0209_3212_001A_1E54);
        check("ready_valid", 64'(bus.seed_valid), 64'd1);
        nsteps = 0;
        repeat (12) cycle(1, 0, 0, 0, 0);
        check("play_steps", 64'(nsteps), 64'd3);
        check("play_gen", 64'(bus.gen_count), 64'd3);
        nsteps = 0;
        repeat (6) cycle(0, 0, 1, 0, 0);
        check("pause_state", 64'(bus.state_o), 64'd4);
        check("pause_steps", 64'(nsteps), 64'd0);
        check("pause_gen", 64'(bus.gen_count), 64'd3);
        repeat (4) cycle(1, 0, 0, 0, 0);
        check("resume_step", 64'(bus.step), 64'd1);
        check("resume_gen", 64'(bus.gen_count), 64'd4);
        cycle(0, 1, 0, 0, 0);
        check("play_rand_state", 64'(bus.state_o), 64'd1);
        check("play_rand_gen", 64'(bus.gen_count), 64'd0);
        cycle(0, 0, 0, 0, 0);
        do_reset();
        cycle(1, 1, 0, 0, 0);
        check("conflict_state", 64'(bus.state_o), 64'd0);
        check("conflict_seed", bus.seed_out, PRE);
        do_reset();
        cycle(0, 0, 0, 1, 64'd0);
`ifdef SEED_CTRL_LOAD_EN
        check("load0_state", 64'(bus.state_o), 64'd2);
        check("load0_seed", bus.seed_out, PRE);
        cycle(0, 0, 0, 1, 64'd1);
        check("load1_seed", bus.seed_out, 64'd1);
`else
        check("noload_state", 64'(bus.state_o), 64'd0);
        check("noload_seed", bus.seed_out, PRE);
        cycle(0, 0, 0, 1, 64'd1);
        check("noload1_seed", bus.seed_out, PRE);
`endif
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            else cycle($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2,
                       $urandom_range(0, 9) < 2,
                       $urandom_range(0, 3) == 0 ? 64'd0 : {$urandom, $urandom});
        end
        @(negedge clk);
        #1;
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
